perceptron_trainer: RTL and testbench
=====================================

PERCEPTRON_TRAINER -- requirements
Module: perceptron_trainer

Interface
REQ-001 Parameter NUM_SAMPLES, default 8, training-set depth (2..16).
REQ-002 Parameter MAX_EPOCHS, default 16, epoch limit before giving up (1..255).
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 reset  input  1  reset, synchronous, active-low.
REQ-005 start  input  1  single-cycle pulse; begins load-then-train sequence.
REQ-006 sample_valid  input  1  training sample present on sample_in/sample_exp.
REQ-007 sample_in  input  8  training input vector.
REQ-008 sample_exp  input  1  expected classification for sample_in.
REQ-009 sample_ready  output  1  trainer accepts a sample this cycle.
REQ-010 p_in  output  8  registered vector driven to the perceptron inputs.
REQ-011 p_exp  output  1  registered expected result driven to the perceptron.
REQ-012 p_result  input  1  perceptron result, registered by the perceptron one cycle after p_in.
REQ-013 w_out  output  32  eight signed 4-bit weights; w[i] at bits 4i+3:4i.
REQ-014 thr_out  output  8  signed activation threshold.
REQ-015 epoch_cnt  output  8  completed epochs.
REQ-016 err_cnt  output  5  misclassifications in the current epoch.
REQ-017 busy, done, converged  output  1 each  status flags.

Function
REQ-018 States: IDLE, LOAD, DRIVE, EVAL, CHECK, DONE.
REQ-019 start in IDLE or DONE -> LOAD; clears w_out, thr_out, epoch_cnt, err_cnt, done, converged, sample index; start in any other state is ignored.
REQ-020 LOAD: sample_ready=1; each cycle with sample_valid=1 stores {sample_in,sample_exp} at the index and increments it; after the NUM_SAMPLES-th accept, sample_ready=0 in the next cycle and state -> DRIVE with index 0.
REQ-021 DRIVE (1 cycle): p_in/p_exp hold buffer[index]; -> EVAL.
REQ-022 EVAL (1 cycle): p_result compared to p_exp; on mismatch, for every i with p_in[i]=1, w[i] += +1 if p_exp=1 else -1; thr_out += -1 if p_exp=1 else +1; err_cnt increments; updates take effect at the end of EVAL, before the next DRIVE.
REQ-023 EVAL -> DRIVE with index+1, or -> CHECK after index NUM_SAMPLES-1; an epoch is therefore 2*NUM_SAMPLES+1 cycles.
REQ-024 CHECK: epoch_cnt increments; err_cnt=0 -> DONE with converged=1; else epoch_cnt reaching MAX_EPOCHS -> DONE with converged=0; else err_cnt cleared, index 0, -> DRIVE.
REQ-025 DONE: done=1, busy=0; w_out/thr_out/epoch_cnt/converged held until next start or reset.
REQ-026 busy=1 in LOAD, DRIVE, EVAL, CHECK.
REQ-027 p_in/p_exp hold the last driven value outside DRIVE/EVAL.

Reset
REQ-028 reset=0 at a rising edge forces IDLE regardless of state, including mid-LOAD or mid-epoch; partially loaded samples are discarded.
REQ-029 Reset values: sample_ready=0, p_in=0x00, p_exp=0, w_out=0, thr_out=0, epoch_cnt=0, err_cnt=0, busy=0, done=0, converged=0.

Configuration
REQ-030 Macro PTRAIN_SATURATE_EN defined: weight updates saturate at -8/+7 and threshold updates at -128/+127.
REQ-031 PTRAIN_SATURATE_EN undefined: weight and threshold updates wrap two's-complement (w=+7 plus 1 gives -8).

Verification
REQ-032 Reset mid-EVAL of epoch 3 -> next cycle IDLE, all outputs at REQ-029 values, busy=0.
REQ-033 start, then 8 samples with sample_valid toggling 1,0,1,... -> exactly 8 accepts, sample_ready=0 after the 8th, a 9th valid sample is not stored.
REQ-034 All samples exp=0, perceptron model returns 0 -> done 17 cycles after the last load accept, converged=1, epoch_cnt=1, w_out=0, thr_out=0.
REQ-035 Single sample in=0x01 exp=1 (NUM_SAMPLES=2, second in=0x00 exp=0), model returns 0 -> after epoch 1, w[0]=+1, other weights 0, thr_out=-1 (0xFF), err_cnt=1.
REQ-036 Model always returns 0, samples in=0x01 exp=1, MAX_EPOCHS=16 -> with macro w[0] stops at +7 and done with converged=0 and epoch_cnt=16; without macro w[0] wraps +7 -> -8 in the epoch after reaching +7.
REQ-037 start pulsed during DRIVE -> ignored; training continues with unchanged epoch_cnt and weights.

Source files
------------

// File: rtl/perceptron_trainer_if.sv
// perceptron_trainer_if
//   Groups every non-clock signal of perceptron_trainer.
//   master : the environment (sample source plus the perceptron's p_result)
//   slave  : the trainer itself
//
// Handshake: a training sample transfers on a rising clk edge where both
//   sample_valid and sample_ready are 1. sample_valid may be raised or dropped
//   in any cycle. sample_in/sample_exp only matter while sample_valid is 1.
//   sample_ready is registered and does not depend on sample_valid in the
//   same cycle.
//
// Signals
//   start        1  single-cycle pulse that begins load-then-train
//   sample_valid 1  sample present on sample_in/sample_exp
//   sample_in    8  training input vector
//   sample_exp   1  expected classification
//   sample_ready 1  trainer accepts a sample this cycle
//   p_in         8  registered vector to the perceptron
//   p_exp        1  registered expected result to the perceptron
//   p_result     1  perceptron result, valid one cycle after p_in
//   w_out       32  eight signed 4-bit weights, w[i] at bits 4i+3:4i
//   thr_out      8  signed activation threshold
//   epoch_cnt    8  completed epochs
//   err_cnt      5  misclassifications in the current epoch
//   busy/done/converged  status flags
//   state_dbg    3  current trainer state encoding
interface perceptron_trainer_if;
    logic        start;
    logic        sample_valid;
    logic [7:0]  sample_in;
    logic        sample_exp;
    logic        sample_ready;
    logic [7:0]  p_in;
    logic        p_exp;
    logic        p_result;
    logic [31:0] w_out;
    logic [7:0]  thr_out;
    logic [7:0]  epoch_cnt;
    logic [4:0]  err_cnt;
    logic        busy;
    logic        done;
    logic        converged;
    logic [2:0]  state_dbg;

    modport master (
        output start, sample_valid, sample_in, sample_exp, p_result,
        input  sample_ready, p_in, p_exp, w_out, thr_out, epoch_cnt,
               err_cnt, busy, done, converged, state_dbg
    );

    modport slave (
        input  start, sample_valid, sample_in, sample_exp, p_result,
        output sample_ready, p_in, p_exp, w_out, thr_out, epoch_cnt,
               err_cnt, busy, done, converged, state_dbg
    );
endinterface

// File: rtl/perceptron_trainer.sv
// perceptron_trainer
//   Loads NUM_SAMPLES training samples, then repeatedly presents them to an
//   external perceptron and applies the perceptron learning rule to eight
//   signed 4-bit weights and a signed 8-bit threshold until an epoch has no
//   misclassification or MAX_EPOCHS epochs have completed.
//
// Ports
//   clk    rising-edge clock
//   reset  synchronous, active-low reset
//   bus    perceptron_trainer_if.slave (see interface file for signal list)
//
// Configuration
//   PTRAIN_SATURATE_EN  defined: weights saturate at -8/+7 and the threshold
//                       at -128/+127. Undefined: both wrap two's-complement.
module perceptron_trainer #(
    parameter int NUM_SAMPLES = 8,
    parameter int MAX_EPOCHS  = 16
) (
    input logic                 clk,
    input logic                 reset,
    perceptron_trainer_if.slave bus
);

    localparam int IW = (NUM_SAMPLES > 1) ? $clog2(NUM_SAMPLES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_SAMPLES - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_DRIVE = 3'd2,
        S_EVAL  = 3'd3,
        S_CHECK = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t        state;
    logic [IW-1:0] idx;
    logic          ready_q;
    logic [7:0]    p_in_q;
    logic          p_exp_q;
    logic [31:0]   w_q;
    logic [7:0]    thr_q;
    logic [7:0]    epoch_q;
    logic [4:0]    err_q;
    logic          busy_q;
    logic          done_q;
    logic          conv_q;

    // Each entry is {sample_in, sample_exp}.
    logic [8:0]    smp_buf [NUM_SAMPLES];

    logic [31:0]   w_upd;
    logic [7:0]    thr_upd;
    logic          mismatch;
    logic [IW-1:0] idx_nxt;
    logic [7:0]    epoch_nxt;

    function automatic logic [3:0] w_step(input logic [3:0] w, input logic up);
`ifdef PTRAIN_SATURATE_EN
        if (up)
            return (w == 4'h7) ? w : w + 4'd1;
        else
            return (w == 4'h8) ? w : w - 4'd1;
`else
        return up ? w + 4'd1 : w - 4'd1;
`endif
    endfunction

    function automatic logic [7:0] thr_step(input logic [7:0] t, input logic up);
`ifdef PTRAIN_SATURATE_EN
        if (up)
            return (t == 8'h7F) ? t : t + 8'd1;
        else
            return (t == 8'h80) ? t : t - 8'd1;
`else
        return up ? t + 8'd1 : t - 8'd1;
`endif
    endfunction

    // Learning rule candidates; only committed in EVAL on a mismatch.
    // A positive example raises the active weights and lowers the threshold.
    always_comb begin
        w_upd = w_q;
        for (int i = 0; i < 8; i++) begin
            if (p_in_q[i])
                w_upd[4*i +: 4] = w_step(w_q[4*i +: 4], p_exp_q);
        end
        thr_upd   = thr_step(thr_q, !p_exp_q);
        mismatch  = (bus.p_result != p_exp_q);
        idx_nxt   = idx + IW'(1);
        epoch_nxt = epoch_q + 8'd1;
    end

    // Sample storage carries no reset; a reset simply restarts the index so
    // partially loaded entries are never used.
    always_ff @(posedge clk) begin
        if (reset && state == S_LOAD && bus.sample_valid && ready_q)
            smp_buf[idx] <= {bus.sample_in, bus.sample_exp};
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= S_IDLE;
            idx     <= '0;
            ready_q <= 1'b0;
            p_in_q  <= 8'h00;
            p_exp_q <= 1'b0;
            w_q     <= 32'h0;
            thr_q   <= 8'h00;
            epoch_q <= 8'h00;
            err_q   <= 5'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            conv_q  <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        state   <= S_LOAD;
                        idx     <= '0;
                        ready_q <= 1'b1;
                        w_q     <= 32'h0;
                        thr_q   <= 8'h00;
                        epoch_q <= 8'h00;
                        err_q   <= 5'd0;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        conv_q  <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (bus.sample_valid) begin
                        if (idx == LAST_IDX) begin
                            // Entry 0 was stored on an earlier accept, so it
                            // can be driven straight away.
                            ready_q <= 1'b0;
                            idx     <= '0;
                            p_in_q  <= smp_buf[0][8:1];
                            p_exp_q <= smp_buf[0][0];
                            state   <= S_DRIVE;
                        end else begin
                            idx <= idx_nxt;
                        end
                    end
                end
                S_DRIVE: begin
                    state <= S_EVAL;
                end
                S_EVAL: begin
                    if (mismatch) begin
                        w_q   <= w_upd;
                        thr_q <= thr_upd;
                        err_q <= err_q + 5'd1;
                    end
                    if (idx == LAST_IDX) begin
                        state <= S_CHECK;
                    end else begin
                        idx     <= idx_nxt;
                        p_in_q  <= smp_buf[idx_nxt][8:1];
                        p_exp_q <= smp_buf[idx_nxt][0];
                        state   <= S_DRIVE;
                    end
                end
                S_CHECK: begin
                    epoch_q <= epoch_nxt;
                    if (err_q == 5'd0) begin
                        conv_q <= 1'b1;
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                        state  <= S_DONE;
                    end else if (epoch_nxt == 8'(MAX_EPOCHS)) begin
                        conv_q <= 1'b0;
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                        state  <= S_DONE;
                    end else begin
                        err_q   <= 5'd0;
                        idx     <= '0;
                        p_in_q  <= smp_buf[0][8:1];
                        p_exp_q <= smp_buf[0][0];
                        state   <= S_DRIVE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.sample_ready = ready_q;
    assign bus.p_in         = p_in_q;
    assign bus.p_exp        = p_exp_q;
    assign bus.w_out        = w_q;
    assign bus.thr_out      = thr_q;
    assign bus.epoch_cnt    = epoch_q;
    assign bus.err_cnt      = err_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.converged    = conv_q;
    assign bus.state_dbg    = state;

endmodule

// File: tb/tb_perceptron_trainer.sv
// tb_perceptron_trainer
//   Directed-vector bench for perceptron_trainer (NUM_SAMPLES=8,
//   MAX_EPOCHS=16). Expected epoch-end and done snapshots are queued by the
//   stimulus and popped by a negedge monitor. Honours PTRAIN_SATURATE_EN.
module tb_perceptron_trainer;

    localparam int N  = 8;
    localparam int ME = 16;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_DRIVE = 3'd2;
    localparam logic [2:0] ST_EVAL  = 3'd3;
    localparam logic [2:0] ST_CHECK = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    perceptron_trainer_if ifc();

    perceptron_trainer #(.NUM_SAMPLES(N), .MAX_EPOCHS(ME)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc)
    );

    // Perceptron stand-in: registered, constant answer chosen per test.
    logic model_mode = 1'b0;
    always @(posedge clk) ifc.p_result <= model_mode;

    int total = 0;
    int bad   = 0;

    // snapshot = {epoch_cnt, err_cnt, w_out, thr_out, converged} (54 bits)
    logic [53:0] chk_exp_q[$];
    // done entry = {cycles since last accept (16), snapshot (54)}
    logic [69:0] done_exp_q[$];

    int   cyc      = 0;
    int   last_acc = 0;
    int   acc_cnt  = 0;
    logic done_prev = 1'b0;

    task automatic check(input string name, input logic [69:0] act, input logic [69:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [53:0] snap();
        return {ifc.epoch_cnt, ifc.err_cnt, ifc.w_out, ifc.thr_out, ifc.converged};
    endfunction

    // ---------------- monitor ----------------
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reset && ifc.sample_valid && ifc.sample_ready) begin
            acc_cnt  <= acc_cnt + 1;
            last_acc <= cyc + 1;
        end
    end

    always @(negedge clk) begin
        logic [53:0] e;
        logic [69:0] d;
        if (reset) begin
            if (ifc.state_dbg == ST_CHECK && chk_exp_q.size() != 0) begin
                e = chk_exp_q.pop_front();
                check("epoch_end", 70'(snap()), 70'(e));
            end
            if (ifc.done && !done_prev && done_exp_q.size() != 0) begin
                d = done_exp_q.pop_front();
                check("done_result", {16'(cyc - last_acc), snap()}, d);
            end
        end
        done_prev <= ifc.done;
    end

    // ---------------- driver tasks ----------------
    logic [7:0] smp_in  [N];
    logic       smp_exp [N];

    task automatic wait_state(input logic [2:0] st, input int budget, input string what);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (ifc.state_dbg == st) return;
        end
        total++;
        bad++;
        $display("FAIL timeout_%s: state %0d not reached in %0d cycles", what, st, budget);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        ifc.start = 1'b1;
        @(negedge clk);
        ifc.start = 1'b0;
    endtask

    task automatic load(input bit toggle, input bit extra);
        int i = 0;
        bit gap = 1'b0;
        for (int c = 0; c < 64 && i < N; c++) begin
            @(negedge clk);
            if (toggle && gap) begin
                ifc.sample_valid = 1'b0;
            end else begin
                ifc.sample_valid = 1'b1;
                ifc.sample_in    = smp_in[i];
                ifc.sample_exp   = smp_exp[i];
            end
            if (ifc.sample_valid && ifc.sample_ready) i++;
            gap = !gap;
        end
        check("load_accepts", 70'(i), 70'(N));
        @(negedge clk);
        check("ready_after_last", 70'(ifc.sample_ready), 70'(0));
        if (extra) begin
            ifc.sample_valid = 1'b1;
            ifc.sample_in    = 8'hAA;
            ifc.sample_exp   = 1'b1;
            @(negedge clk);
        end
        ifc.sample_valid = 1'b0;
    endtask

    task automatic check_reset(input string name);
        check({name, "_outputs"},
              70'({ifc.sample_ready, ifc.p_in, ifc.p_exp, ifc.w_out, ifc.thr_out,
                   ifc.epoch_cnt, ifc.err_cnt, ifc.busy, ifc.done, ifc.converged}),
              70'(0));
        check({name, "_state"}, 70'(ifc.state_dbg), 70'(ST_IDLE));
    endtask

    // w[0] after k positive mismatches on bit 0
    function automatic logic [3:0] w0_after(input int k);
`ifdef PTRAIN_SATURATE_EN
        return (k > 7) ? 4'd7 : 4'(k);
`else
        return 4'(k);
`endif
    endfunction

    task automatic push_single_pos_epochs(input int kmax);
        for (int k = 1; k <= kmax; k++)
            chk_exp_q.push_back({8'(k - 1), 5'd1, {28'd0, w0_after(k)}, 8'(-k), 1'b0});
    endtask

    task automatic set_single_pos();
        for (int i = 0; i < N; i++) begin
            smp_in[i]  = (i == 0) ? 8'h01 : 8'h00;
            smp_exp[i] = (i == 0);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int acc_base;
        ifc.start        = 1'b0;
        ifc.sample_valid = 1'b0;
        ifc.sample_in    = 8'h00;
        ifc.sample_exp   = 1'b0;

        // Reset state
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check_reset("reset");
        reset = 1'b1;

        // All samples negative, perceptron answers 0: converges in epoch 1,
        // done 17 cycles after the last accept. Valid toggles 1,0,1,...
        // and a 9th sample is offered after loading finishes.
        model_mode = 1'b0;
        for (int i = 0; i < N; i++) begin
            smp_in[i]  = 8'(8'h11 * i + 1);
            smp_exp[i] = 1'b0;
        end
        chk_exp_q.push_back({8'd0, 5'd0, 32'd0, 8'd0, 1'b0});
        done_exp_q.push_back({16'd17, 8'd1, 5'd0, 32'd0, 8'd0, 1'b1});
        acc_base = acc_cnt;
        pulse_start();
        load(1'b1, 1'b1);
        wait_state(ST_DONE, 40, "converge");
        @(negedge clk);
        check("accept_count", 70'(acc_cnt - acc_base), 70'(8));
        check("busy_in_done", 70'(ifc.busy), 70'(0));

        // One positive sample on bit 0, perceptron answers 0: +1 on w[0] and
        // -1 on thr per epoch, no convergence within 16 epochs (272 cycles).
        set_single_pos();
        push_single_pos_epochs(16);
        done_exp_q.push_back({16'd272, 8'd16, 5'd1, {28'd0, w0_after(16)}, 8'hF0, 1'b0});
        pulse_start();
        load(1'b0, 1'b0);
        wait_state(ST_DONE, 400, "max_epochs");
        check("epochs_consumed", 70'(chk_exp_q.size()), 70'(0));

        // start during DRIVE is ignored; then reset during EVAL of epoch 3.
        push_single_pos_epochs(2);
        pulse_start();
        load(1'b0, 1'b0);
        wait_state(ST_CHECK, 40, "epoch1");
        wait_state(ST_DRIVE, 4, "epoch2_drive");
        ifc.start = 1'b1;
        @(negedge clk);
        ifc.start = 1'b0;
        check("start_ignored_state", 70'(ifc.state_dbg), 70'(ST_EVAL));
        check("start_ignored_ready", 70'(ifc.sample_ready), 70'(0));
        wait_state(ST_CHECK, 40, "epoch2");
        wait_state(ST_EVAL, 4, "epoch3_eval");
        reset = 1'b0;
        @(negedge clk);
        check_reset("mid_eval_reset");
        reset = 1'b1;

        // Perceptron answers 1: negative sample 0x81 lowers w[0] and w[7]
        // and raises thr; positive 0xFF samples match.
        model_mode = 1'b1;
        for (int i = 0; i < N; i++) begin
            smp_in[i]  = (i == 0) ? 8'h81 : 8'hFF;
            smp_exp[i] = (i != 0);
        end
        chk_exp_q.push_back({8'd0, 5'd1, 32'hF000000F, 8'h01, 1'b0});
        pulse_start();
        load(1'b0, 1'b0);
        wait_state(ST_CHECK, 40, "neg_epoch1");
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        model_mode = 1'b0;

        check("queues_empty", 70'(chk_exp_q.size() + done_exp_q.size()), 70'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
